core_seq_ctrl: RTL and testbench
================================

// Module: core_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32 core: drives FETCH -> EXEC -> [MEM] -> WB.
//  Handshakes with the instruction and data memories and latches the fetched instruction.
//  Emits single-cycle pc and register-file write strobes, so the datapath updates at most once per instruction.
//  Halts on ebreak or an illegal opcode, and faults on a memory timeout.
// PARAMETERS
//  XLEN      32   instruction/data width
//  TIMEOUT   255  max wait cycles for ifu_ready/lsu_ready before fault (>=1)
//  CNT_W     32   width of performance counters
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst          in   1     asynchronous, active-low reset
//  start        in   1     level; leave IDLE and begin fetching
//  inst         in   XLEN  instruction-memory read data, valid when ifu_ready=1
//  ifu_req      out  1     instruction fetch request
//  ifu_ready    in   1     fetch done; inst valid this cycle
//  ir           out  XLEN  latched instruction, feeds decode/datapath
//  lsu_req      out  1     data memory request
//  lsu_wen      out  1     data memory write (store) qualifier
//  lsu_ready    in   1     data access complete
//  reg_wen      out  1     register-file write strobe
//  pc_wen       out  1     pc register update strobe
//  state        out  3     IDLE=0 FETCH=1 EXEC=2 MEM=3 WB=4 HALT=5 ERR=6
//  halt         out  1     ebreak or illegal opcode reached (sticky)
//  illegal      out  1     halt caused by unknown opcode (sticky)
//  bus_err      out  1     memory handshake timeout (sticky)
//  cycle_cnt    out  CNT_W active-cycle counter
//  instret_cnt  out  CNT_W retired-instruction counter
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; ir=0; all strobes, flags and counters 0; pending requests dropped immediately.
//  IDLE: start=1 -> FETCH next cycle. start is ignored in every other state.
//  FETCH: ifu_req=1, held until ifu_ready=1. On the handshake cycle ir<=inst -> EXEC.
//  EXEC: single cycle; decodes ir[6:0].
//   - ir==32'h00100073 (ebreak) -> HALT.
//   - 0000011 (load) or 0100011 (store) -> MEM.
//   - 0110111 0010111 1101111 1100111 1100011 0010011 0110011 -> WB.
//   - any other opcode -> HALT with illegal=1.
//  MEM: lsu_req=1; lsu_wen=1 only for store; both held until lsu_ready=1 -> WB.
//  WB: pc_wen=1 for exactly one cycle; -> FETCH.
//   - reg_wen=1 unless opcode is store/branch, or ir[11:7]==0.
//  HALT and ERR are terminal until reset; all strobes are 0 in both.
//  Timeout: a wait counter clears on entry to FETCH/MEM and increments each cycle ready=0.
//   - When it reaches TIMEOUT -> ERR, bus_err=1.
//   - If ready=1 on the same cycle the counter reaches TIMEOUT, ready wins and the handshake completes.
//  Latency: minimum 3 cycles for non-memory ops, 4 for load/store (zero-wait memories).
//  All outputs are registered, or decoded purely from state and ir.
// CONFIGURATION
//  CORE_SEQ_PERF_CNT_EN defined:
//   - cycle_cnt +1 every cycle state is FETCH/EXEC/MEM/WB.
//   - instret_cnt +1 on each WB cycle.
//   - Both wrap modulo 2^CNT_W.
//  Not defined: both counters tied to 0 and no counter flops are built.
// TESTING
//  1 addi x1,x0,1 (00100093), ifu_ready same cycle -> FETCH,EXEC,WB. WB: pc_wen=1, reg_wen=1. instret_cnt=1.
//  2 sw x1,0(x2) (00112023), lsu_ready after 2 cycles -> lsu_req=lsu_wen=1 for 3 cycles. WB: reg_wen=0, pc_wen=1.
//  3 beq (00000063) -> reg_wen=0 in WB. addi x0,x0,0 (00000013) -> reg_wen=0, pc_wen=1.
//  4 ebreak (00100073) -> HALT, halt=1 the cycle after EXEC, no pc_wen. inst 0000007F -> halt=1, illegal=1.
//  5 TIMEOUT=4, ifu_ready held 0 -> ERR, bus_err=1 after 4 wait cycles. ready=1 on the 4th cycle -> EXEC, no error.
//  6 rst=0 mid-MEM -> lsu_req=0 and state=0 immediately. After release, start=1 refetches cleanly.

Source files
------------

// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH -> EXEC -> [MEM] -> WB sequencer for the RV32 core.
// Optional performance counters are built only when CORE_SEQ_PERF_CNT_EN is defined.
module core_seq_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XLEN-1:0]  inst,
  output logic             ifu_req,
  input  logic             ifu_ready,
  output logic [XLEN-1:0]  ir,
  output logic             lsu_req,
  output logic             lsu_wen,
  input  logic             lsu_ready,
  output logic             reg_wen,
  output logic             pc_wen,
  output logic [2:0]       state,
  output logic             halt,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t            state_q, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              halt_q, illegal_q, bus_err_q;
  logic              ir_ld, set_halt, set_ill, set_err, waiting;

  logic [6:0] opcode;
  logic       is_ebreak, is_load, is_store, is_branch, is_alu, timed_out;

  assign opcode    = ir[6:0];
  assign is_ebreak = (ir == XLEN'(32'h0010_0073));
  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_branch = (opcode == 7'b1100011);
  assign is_alu    = opcode inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                    7'b1100011, 7'b0010011, 7'b0110011};
  // Ready on the final allowed wait cycle still completes the handshake.
  assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state_q;
    ir_ld     = 1'b0;
    set_halt  = 1'b0;
    set_ill   = 1'b0;
    set_err   = 1'b0;
    waiting   = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (ifu_ready) begin
          state_nxt = S_EXEC;
          ir_ld     = 1'b1;
        end else if (timed_out) begin
          state_nxt = S_ERR;
          set_err   = 1'b1;
        end else begin
          waiting = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_ebreak) begin
          state_nxt = S_HALT;
          set_halt  = 1'b1;
        end else if (is_load || is_store) begin
          state_nxt = S_MEM;
        end else if (is_alu) begin
          state_nxt = S_WB;
        end else begin
          state_nxt = S_HALT;
          set_halt  = 1'b1;
          set_ill   = 1'b1;
        end
      end
      S_MEM: begin
        if (lsu_ready) begin
          state_nxt = S_WB;
        end else if (timed_out) begin
          state_nxt = S_ERR;
          set_err   = 1'b1;
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB:   state_nxt = S_FETCH;
      S_HALT: state_nxt = S_HALT;
      S_ERR:  state_nxt = S_ERR;
      default: begin
        state_nxt = S_ERR;
        set_err   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ir        <= '0;
      wait_cnt  <= '0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (ir_ld) ir <= inst;
      // Any state change clears the wait counter, so it starts fresh on FETCH/MEM entry.
      if (state_nxt != state_q) wait_cnt <= '0;
      else if (waiting)         wait_cnt <= wait_cnt + WAIT_W'(1);
      if (set_halt) halt_q    <= 1'b1;
      if (set_ill)  illegal_q <= 1'b1;
      if (set_err)  bus_err_q <= 1'b1;
    end
  end

  assign state   = state_q;
  assign ifu_req = (state_q == S_FETCH);
  assign lsu_req = (state_q == S_MEM);
  assign lsu_wen = (state_q == S_MEM) && is_store;
  assign pc_wen  = (state_q == S_WB);
  assign reg_wen = (state_q == S_WB) && !is_store && !is_branch && (ir[11:7] != 5'd0);
  assign halt    = halt_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

`ifdef CORE_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ret_q;
  logic             active;

  assign active = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                  (state_q == S_MEM)   || (state_q == S_WB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (active)            cyc_q <= cyc_q + CNT_W'(1);
      if (state_q == S_WB)   ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: per-instruction transaction model expands into per-cycle
// stimulus/expectation queues that are replayed in lockstep against the DUT.
module tb_core_seq_ctrl;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 32;
  localparam int SW      = 3 + 32;
  localparam int EW      = 11 + 32;
`ifdef CORE_SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_MEM   = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

  logic             clk, rst, start, ifu_ready, lsu_ready;
  logic [XLEN-1:0]  inst, ir;
  logic             ifu_req, lsu_req, lsu_wen, reg_wen, pc_wen, halt, illegal, bus_err;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  core_seq_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .inst(inst), .ifu_req(ifu_req),
    .ifu_ready(ifu_ready), .ir(ir), .lsu_req(lsu_req), .lsu_wen(lsu_wen),
    .lsu_ready(lsu_ready), .reg_wen(reg_wen), .pc_wen(pc_wen), .state(state),
    .halt(halt), .illegal(illegal), .bus_err(bus_err), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [SW-1:0] stim_q[$];
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // transaction-level model state
  logic [31:0] ir_m;
  bit halt_m, ill_m, be_m, store_m, cut_m, done_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic int rdel();
    if ($urandom_range(0, 3) != 0) return $urandom_range(0, 2);
    return $urandom_range(0, TIMEOUT + 1);
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [12];
    logic [31:0] r;
    int idx;
    ops = '{7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h13, 7'h33, 7'h7F, 7'h73, 7'h0B};
    idx = $urandom_range(0, 12);
    if (idx == 12) return 32'h0010_0073;
    r = $urandom;
    if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
    r[6:0] = ops[idx];
    return r;
  endfunction

  task automatic push_cyc(input logic [2:0] st, input bit s, input bit fr, input bit lr,
                          input logic [31:0] in, input bit rwe);
    stim_q.push_back({s, fr, lr, in});
    exp_q.push_back({st, st == ST_FETCH, st == ST_MEM, (st == ST_MEM) && store_m, rwe,
                     st == ST_WB, halt_m, ill_m, be_m, ir_m});
  endtask

  task automatic begin_ep();
    ir_m = '0; halt_m = 0; ill_m = 0; be_m = 0; store_m = 0; cut_m = 0; done_m = 0;
    repeat ($urandom_range(0, 2)) push_cyc(ST_IDLE, 0, rb(), rb(), $urandom, 0);
    push_cyc(ST_IDLE, 1, rb(), rb(), $urandom, 0);
  endtask

  // One instruction: fd/md are wait cycles before ready; >= TIMEOUT means never ready.
  task automatic gen_instr(input logic [31:0] in, input int fd, input int md, input bit cut);
    logic [6:0] op;
    bit is_mem, is_wb;
    if (done_m) return;
    for (int w = 0; w < fd && w < TIMEOUT; w++) push_cyc(ST_FETCH, rb(), 0, rb(), $urandom, 0);
    if (fd >= TIMEOUT) begin be_m = 1; done_m = 1; return; end
    push_cyc(ST_FETCH, rb(), 1, rb(), in, 0);
    ir_m = in;
    push_cyc(ST_EXEC, rb(), rb(), rb(), $urandom, 0);
    op = in[6:0];
    if (in == 32'h0010_0073) begin halt_m = 1; done_m = 1; return; end
    is_mem = (op == 7'h03) || (op == 7'h23);
    is_wb  = op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h13, 7'h33};
    if (!is_mem && !is_wb) begin halt_m = 1; ill_m = 1; done_m = 1; return; end
    if (is_mem) begin
      store_m = (op == 7'h23);
      if (cut) begin
        push_cyc(ST_MEM, rb(), rb(), 0, $urandom, 0);
        cut_m = 1; done_m = 1; return;
      end
      for (int w = 0; w < md && w < TIMEOUT; w++) push_cyc(ST_MEM, rb(), rb(), 0, $urandom, 0);
      if (md >= TIMEOUT) begin be_m = 1; done_m = 1; return; end
      push_cyc(ST_MEM, rb(), rb(), 1, $urandom, 0);
    end
    push_cyc(ST_WB, rb(), rb(), rb(), $urandom,
             (op != 7'h23) && (op != 7'h63) && (in[11:7] != 5'd0));
  endtask

  task automatic end_ep();
    if (halt_m || be_m)
      repeat (3) push_cyc(be_m ? ST_ERR : ST_HALT, rb(), rb(), rb(), $urandom, 0);
  endtask

  // driver: async reset, then replay the queued cycles
  task automatic run_episode();
    logic [SW-1:0] s;
    logic [EW-1:0] e;
    logic [31:0] cyc_m, ret_m;
    logic [63:0] ecnt;
    rst = 1'b0;
    #1;
    check("reset_outs", 64'({state, ifu_req, lsu_req, lsu_wen, reg_wen, pc_wen, halt, illegal, bus_err}), 64'd0);
    check("reset_ir", 64'(ir), 64'd0);
    check("reset_cnt", 64'({cycle_cnt, instret_cnt}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc_m = '0;
    ret_m = '0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      {start, ifu_ready, lsu_ready, inst} = s;
      check("state_strobes", 64'({state, ifu_req, lsu_req, lsu_wen, reg_wen, pc_wen, halt, illegal, bus_err}),
            64'(e[42:32]));
      check("ir", 64'(ir), 64'(e[31:0]));
      ecnt = PERF ? {cyc_m, ret_m} : 64'd0;
      check("perf_cnt", 64'({cycle_cnt, instret_cnt}), ecnt);
      if (e[42:40] inside {ST_FETCH, ST_EXEC, ST_MEM, ST_WB}) cyc_m++;
      if (e[42:40] == ST_WB) ret_m++;
      if (exp_q.size() > 0) @(negedge clk);
    end
    @(posedge clk);
    #2;
    if (cut_m) check("mem_before_reset", 64'({state, lsu_req}), 64'({ST_MEM, 1'b1}));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ifu_ready = 1'b0; lsu_ready = 1'b0; inst = '0;
    repeat (2) @(posedge clk);
    #2;

    begin_ep();
    gen_instr(32'h0010_0093, 0, 0, 0);
    gen_instr(32'h0011_2023, 0, 2, 0);
    gen_instr(32'h0000_0063, 1, 0, 0);
    gen_instr(32'h0000_0013, 0, 0, 0);
    gen_instr(32'h0010_0073, 0, 0, 0);
    end_ep();
    run_episode();

    begin_ep();
    gen_instr(32'h0000_0083, 0, 0, 0);
    gen_instr(32'h0000_007F, 0, 0, 0);
    end_ep();
    run_episode();

    begin_ep();
    gen_instr(32'h0010_0093, TIMEOUT - 1, 0, 0);
    gen_instr(32'h0010_0093, TIMEOUT, 0, 0);
    end_ep();
    run_episode();

    begin_ep();
    gen_instr(32'h0000_2083, 0, TIMEOUT - 1, 0);
    gen_instr(32'h0000_2083, 0, TIMEOUT, 0);
    end_ep();
    run_episode();

    begin_ep();
    gen_instr(32'h0001_2083, 0, 0, 1);
    end_ep();
    run_episode();

    for (int ep = 0; ep < 40; ep++) begin
      int ninst;
      bit cut_ep;
      logic [31:0] in;
      begin_ep();
      ninst  = $urandom_range(1, 6);
      cut_ep = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < ninst; i++) begin
        in = rand_inst();
        if (cut_ep && i == ninst - 1) in[6:0] = rb() ? 7'h03 : 7'h23;
        gen_instr(in, rdel(), rdel(), cut_ep && i == ninst - 1);
      end
      end_ep();
      run_episode();
    end

    run_episode();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
